// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the instruction-fetch stage: datapath width, bubble
// encoding, fetch FSM states and the BTB entry layout.
package fetch_stage_pkg;

  localparam int WORD_SIZE = 16;

  typedef logic [WORD_SIZE-1:0] word_t;

  localparam word_t BUBBLE_INSTR = 16'hF01C;

  typedef enum logic [1:0] {
    ST_START = 2'd0,
    ST_FETCH = 2'd1,
    ST_HOLD  = 2'd2
  } fetch_state_t;

  // tag holds pc >> idx_bits, zero-extended, so one layout serves any index width
  typedef struct packed {
    logic       valid;
    word_t      tag;
    word_t      target;
    logic [1:0] ctr;
  } btb_entry_t;

  function automatic logic [1:0] ctr_train(input logic [1:0] ctr, input logic taken);
    if (taken) return (ctr == 2'b11) ? ctr : ctr + 2'b01;
    return (ctr == 2'b00) ? ctr : ctr - 2'b01;
  endfunction

endpackage

// File: rtl/branch_target_buffer.sv
// Direct-mapped branch target buffer with 2-bit saturating counters.
// Lookup is combinational; training lands on the next clock edge.
module branch_target_buffer
  import fetch_stage_pkg::*;
#(
  parameter int IDX_BITS = 4
) (
  input  logic  clk,
  input  logic  reset_n,
  input  word_t lookup_pc,
  output logic  predict_taken,
  output word_t predict_target,
  input  logic  update_valid,
  input  word_t update_pc,
  input  logic  update_taken,
  input  word_t update_target
);

  localparam int ENTRIES = 2 ** IDX_BITS;

  btb_entry_t          entries_q [ENTRIES];
  logic [IDX_BITS-1:0] lk_idx;
  logic [IDX_BITS-1:0] up_idx;
  word_t               lk_tag;
  word_t               up_tag;
  btb_entry_t          lk_entry;
  btb_entry_t          up_entry;
  logic                up_hit;

  assign lk_idx   = lookup_pc[IDX_BITS-1:0];
  assign up_idx   = update_pc[IDX_BITS-1:0];
  assign lk_tag   = lookup_pc >> IDX_BITS;
  assign up_tag   = update_pc >> IDX_BITS;
  assign lk_entry = entries_q[lk_idx];
  assign up_entry = entries_q[up_idx];
  assign up_hit   = up_entry.valid && (up_entry.tag == up_tag);

  assign predict_taken  = lk_entry.valid && (lk_entry.tag == lk_tag) && lk_entry.ctr[1];
  assign predict_target = lk_entry.target;

  // NOTE: the table is small flop storage, so every entry is reset; a RAM-backed
  // table would instead need only its valid bits cleared.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        entries_q[i] <= '{valid: 1'b0, tag: '0, target: '0, ctr: 2'b01};
      end
    end else if (update_valid) begin
      if (up_hit) begin
        entries_q[up_idx].ctr <= ctr_train(up_entry.ctr, update_taken);
        if (update_taken) entries_q[up_idx].target <= update_target;
      end else if (update_taken) begin
        entries_q[up_idx] <= '{valid: 1'b1, tag: up_tag, target: update_target, ctr: 2'b10};
      end
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives instruction-memory reads, and
// presents {pc+1, instruction, prediction} to IF/ID with stall and redirect support.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter int    BTB_IDX_BITS = 4,
  parameter word_t RESET_PC     = 16'h0000
) (
  input  logic  clk,
  input  logic  reset_n,
  input  logic  stall,
  input  logic  redirect,
  input  word_t redirect_pc,
  input  logic  update_valid,
  input  word_t update_pc,
  input  logic  update_taken,
  input  word_t update_target,
  output logic  i_readM,
  output word_t i_address,
  input  word_t i_data,
  input  logic  i_ready,
  output logic  if_valid,
  output word_t if_pc_plus_1,
  output word_t if_instr,
  output logic  if_predict
);

  fetch_state_t state_q, state_d;
  word_t        pc_q;
  word_t        pc_plus_1;
  word_t        next_pc;
  word_t        btb_target;
  logic         btb_taken;
  logic         fetch_done;
  word_t        hold_instr_q;
  word_t        hold_pc_plus_1_q;
  word_t        hold_next_pc_q;
  logic         hold_predict_q;

  branch_target_buffer #(.IDX_BITS(BTB_IDX_BITS)) u_btb (
    .clk           (clk),
    .reset_n       (reset_n),
    .lookup_pc     (pc_q),
    .predict_taken (btb_taken),
    .predict_target(btb_target),
    .update_valid  (update_valid),
    .update_pc     (update_pc),
    .update_taken  (update_taken),
    .update_target (update_target)
  );

  assign pc_plus_1  = pc_q + word_t'(1);
  assign next_pc    = btb_taken ? btb_target : pc_plus_1;
  assign fetch_done = (state_q == ST_FETCH) && i_ready;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, regardless of block ordering.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= ST_START;
    else          state_q <= state_d;
  end

  // NOTE: every combinational output gets a default first, so no path infers a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_START: state_d = ST_FETCH;
      ST_FETCH: if (i_ready && stall) state_d = ST_HOLD;
      ST_HOLD:  if (!stall) state_d = ST_FETCH;
      default:  state_d = ST_START;
    endcase
    if (redirect) state_d = ST_FETCH;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc_q             <= RESET_PC;
      hold_instr_q     <= BUBBLE_INSTR;
      hold_pc_plus_1_q <= '0;
      hold_next_pc_q   <= '0;
      hold_predict_q   <= 1'b0;
    end else if (redirect) begin
      pc_q <= redirect_pc;
    end else if (fetch_done && stall) begin
      hold_instr_q     <= i_data;
      hold_pc_plus_1_q <= pc_plus_1;
      hold_next_pc_q   <= next_pc;
      hold_predict_q   <= btb_taken;
    end else if (fetch_done) begin
      pc_q <= next_pc;
    end else if (state_q == ST_HOLD && !stall) begin
      pc_q <= hold_next_pc_q;
    end
  end

  always_comb begin
    i_readM      = 1'b0;
    i_address    = pc_q;
    if_valid     = 1'b0;
    if_pc_plus_1 = pc_plus_1;
    if_instr     = BUBBLE_INSTR;
    if_predict   = 1'b0;
    unique case (state_q)
      ST_FETCH: begin
        i_readM = 1'b1;
        if (i_ready) begin
          if_valid   = 1'b1;
          if_instr   = i_data;
          if_predict = btb_taken;
        end
      end
      ST_HOLD: begin
        if_valid     = 1'b1;
        if_instr     = hold_instr_q;
        if_predict   = hold_predict_q;
        if_pc_plus_1 = hold_pc_plus_1_q;
      end
      default: ;
    endcase
    // whatever arrives in a redirect cycle belongs to the wrong path
    if (redirect) begin
      if_valid   = 1'b0;
      if_instr   = BUBBLE_INSTR;
      if_predict = 1'b0;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios followed by random
// stimulus, all compared against a behavioural model of the fetch rules.
module tb_fetch_stage;
  import fetch_stage_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        stall = 1'b0, redirect = 1'b0, update_valid = 1'b0, update_taken = 1'b0, i_ready = 1'b0;
  logic [15:0] redirect_pc = '0, update_pc = '0, update_target = '0, i_data = '0;
  logic        i_readM, if_valid, if_predict;
  logic [15:0] i_address, if_pc_plus_1, if_instr;

  always #5 clk = ~clk;

  fetch_stage #(.BTB_IDX_BITS(4), .RESET_PC(16'h0000)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .stall        (stall),
    .redirect     (redirect),
    .redirect_pc  (redirect_pc),
    .update_valid (update_valid),
    .update_pc    (update_pc),
    .update_taken (update_taken),
    .update_target(update_target),
    .i_readM      (i_readM),
    .i_address    (i_address),
    .i_data       (i_data),
    .i_ready      (i_ready),
    .if_valid     (if_valid),
    .if_pc_plus_1 (if_pc_plus_1),
    .if_instr     (if_instr),
    .if_predict   (if_predict)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: PC, whether fetching has begun, whether an instruction is
  // parked, and the BTB as plain integer arrays.
  int  m_pc;
  bit  m_started, m_hold;
  int  h_instr, h_pp1, h_next;
  bit  h_pred;
  bit  b_valid [16];
  int  b_tag [16], b_target [16], b_ctr [16];
  bit  mem_echo;

  logic [15:0] o_addr, o_instr, o_pp1;
  logic        o_valid, o_pred, o_readM;

  task automatic model_reset();
    m_pc = 0; m_started = 0; m_hold = 0;
    for (int i = 0; i < 16; i++) begin
      b_valid[i] = 0; b_tag[i] = 0; b_target[i] = 0; b_ctr[i] = 1;
    end
  endtask

  // Called at a negedge; asserts reset mid-cycle and checks the immediate response.
  task automatic reset_mid();
    #2 reset_n = 1'b0;
    #1;
    check("rst_readM", i_readM, 0);
    check("rst_valid", if_valid, 0);
    check("rst_addr", i_address, 16'h0000);
    check("rst_pp1", if_pc_plus_1, 16'h0001);
    check("rst_instr", if_instr, BUBBLE_INSTR);
    check("rst_pred", if_predict, 0);
    model_reset();
    stall = 0; redirect = 0; update_valid = 0; i_ready = 0;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  // One clock cycle: drive at negedge, check at +1, advance the model at posedge.
  task automatic step(input bit st, input bit rd, input int rpc, input bit uv,
                      input int upc, input bit ut, input int utg, input bit rdy);
    int idx, nxt, e_instr, e_pp1;
    bit hit, pred, e_valid, e_pred, e_readM;
    stall = st; redirect = rd; redirect_pc = 16'(rpc);
    update_valid = uv; update_pc = 16'(upc); update_taken = ut; update_target = 16'(utg);
    i_ready = rdy;
    i_data = mem_echo ? i_address : 16'($urandom);
    #1;
    o_addr = i_address; o_instr = if_instr; o_pp1 = if_pc_plus_1;
    o_valid = if_valid; o_pred = if_predict; o_readM = i_readM;

    idx  = m_pc % 16;
    hit  = b_valid[idx] && (b_tag[idx] == m_pc / 16);
    pred = hit && (b_ctr[idx] >= 2);
    nxt  = pred ? b_target[idx] : (m_pc + 1) % 65536;
    if (!m_started) begin
      e_readM = 0; e_valid = 0; e_instr = 0; e_pred = 0; e_pp1 = (m_pc + 1) % 65536;
    end else if (m_hold) begin
      e_readM = 0; e_valid = !rd; e_instr = h_instr; e_pred = h_pred; e_pp1 = h_pp1;
    end else begin
      e_readM = 1; e_valid = rdy && !rd; e_instr = int'(i_data); e_pred = pred;
      e_pp1 = (m_pc + 1) % 65536;
    end
    if (!e_valid) begin
      e_instr = int'(BUBBLE_INSTR); e_pred = 0;
    end
    check("readM", o_readM, e_readM);
    check("valid", o_valid, e_valid);
    check("instr", o_instr, e_instr);
    check("predict", o_pred, e_pred);
    if (e_readM) check("address", o_addr, m_pc);
    if (e_valid) check("pc_plus_1", o_pp1, e_pp1);

    @(posedge clk);
    if (rd) begin
      m_pc = rpc; m_hold = 0; m_started = 1;
    end else if (!m_started) begin
      m_started = 1;
    end else if (m_hold) begin
      if (!st) begin m_pc = h_next; m_hold = 0; end
    end else if (rdy) begin
      if (st) begin
        m_hold = 1; h_instr = int'(i_data); h_pred = pred;
        h_pp1 = (m_pc + 1) % 65536; h_next = nxt;
      end else begin
        m_pc = nxt;
      end
    end
    if (uv) begin
      idx = upc % 16;
      if (b_valid[idx] && b_tag[idx] == upc / 16) begin
        if (ut) begin
          b_ctr[idx] = (b_ctr[idx] == 3) ? 3 : b_ctr[idx] + 1;
          b_target[idx] = utg;
        end else begin
          b_ctr[idx] = (b_ctr[idx] == 0) ? 0 : b_ctr[idx] - 1;
        end
      end else if (ut) begin
        b_valid[idx] = 1; b_tag[idx] = upc / 16; b_target[idx] = utg; b_ctr[idx] = 2;
      end
    end
    @(negedge clk);
  endtask

  task automatic idle(input bit rdy);
    step(0, 0, 0, 0, 0, 0, 0, rdy);
  endtask

  task automatic train(input int upc, input bit ut, input int utg);
    step(0, 0, 0, 1, upc, ut, utg, 0);
  endtask

  task automatic jump(input int rpc);
    step(0, 1, rpc, 0, 0, 0, 0, 0);
  endtask

  initial begin
    mem_echo = 1;
    model_reset();
    @(negedge clk);
    reset_mid();

    // Zero-wait sequential fetch from reset
    idle(1);
    check("start_valid", o_valid, 0);
    check("start_readM", o_readM, 0);
    for (int k = 0; k < 4; k++) begin
      idle(1);
      check("seq_instr", o_instr, k);
      check("seq_pp1", o_pp1, k + 1);
      check("seq_pred", o_pred, 0);
    end

    // Stall three cycles with pc=5 returned
    idle(1);
    step(1, 0, 0, 0, 0, 0, 0, 1);
    check("stall_instr", o_instr, 5);
    check("stall_valid", o_valid, 1);
    for (int k = 0; k < 2; k++) begin
      step(1, 0, 0, 0, 0, 0, 0, 1);
      check("hold_readM", o_readM, 0);
      check("hold_instr", o_instr, 5);
    end
    idle(0);
    check("release_instr", o_instr, 5);
    idle(0);
    check("after_hold_addr", o_addr, 6);

    // BTB training at pc 8
    train(8, 1, 20);
    train(8, 1, 20);
    jump(8);
    idle(1);
    check("btb_pred_taken", o_pred, 1);
    idle(0);
    check("btb_target_addr", o_addr, 20);
    train(8, 0, 0);
    train(8, 0, 0);
    jump(8);
    idle(1);
    check("btb_pred_weak", o_pred, 0);
    idle(0);
    check("btb_fallthrough", o_addr, 9);

    // Redirect beats stall and i_ready, then two wait states
    step(1, 1, 40, 0, 0, 0, 0, 1);
    check("redirect_valid", o_valid, 0);
    idle(0);
    check("redirect_addr", o_addr, 40);
    check("wait_valid", o_valid, 0);
    idle(0);
    check("wait_addr", o_addr, 40);
    idle(1);
    check("wait_done_instr", o_instr, 40);

    // Aliasing: entry for pc 3 must not match pc 19
    train(3, 1, 50);
    train(3, 1, 50);
    jump(19);
    idle(1);
    check("alias_pred", o_pred, 0);
    check("alias_pp1", o_pp1, 20);
    idle(0);
    check("alias_next", o_addr, 20);
    jump(3);
    idle(1);
    check("alias_owner_pred", o_pred, 1);

    // Reset while parked in HOLD drops the buffered instruction
    step(1, 0, 0, 0, 0, 0, 0, 1);
    reset_mid();

    // Random stimulus against the model
    mem_echo = 0;
    for (int n = 0; n < 3000; n++) begin
      int rpc;
      rpc = ($urandom_range(0, 7) == 0) ? 65535 - int'($urandom_range(0, 3))
                                        : int'($urandom_range(0, 63));
      step(($urandom_range(0, 3) == 0), ($urandom_range(0, 9) == 0), rpc,
           ($urandom_range(0, 4) < 2), int'($urandom_range(0, 63)),
           ($urandom_range(0, 2) != 0), int'($urandom_range(0, 63)),
           ($urandom_range(0, 9) < 7));
      if ($urandom_range(0, 399) == 0) reset_mid();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
